// File: rtl/mvm_pkg.sv
// Shared constants, beat field positions and opcode encoding for the mvm block.
package mvm_pkg;

    localparam int TDATAW   = 128;
    localparam int IDW      = 32;
    localparam int DESTW    = 12;
    localparam int USERW    = 32;

    localparam int NROWS    = 64;
    localparam int ROW_AW   = 6;
    localparam int LANES    = 4;

    localparam int DATA_LSB  = 0;
    localparam int DATA_MSB  = 31;
    localparam int VALID_BIT = 32;
    localparam int OP_LSB    = 33;
    localparam int OP_MSB    = 34;
    localparam int SEL_LSB   = 35;
    localparam int SEL_MSB   = 98;

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_READ  = 2'b01,
        OP_MVM   = 2'b10,
        OP_WRITE = 2'b11
    } opcode_e;

    // Index of the lowest set bit; returns 0 for an all-zero select.
    function automatic logic [ROW_AW-1:0] lowest_set(input logic [NROWS-1:0] sel);
        logic [ROW_AW-1:0] idx;
        idx = '0;
        for (int i = NROWS - 1; i >= 0; i--) begin
            if (sel[i]) idx = ROW_AW'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/mvm_dot4.sv
// Combinational 4-lane signed int8 dot product with a 32-bit sign-extended result.
module mvm_dot4
    import mvm_pkg::*;
(
    input  logic [31:0] i_x,
    input  logic [31:0] i_w,
    output logic [31:0] o_sum
);

    logic signed [15:0] w_prod [LANES];
    logic signed [31:0] w_acc;

    always_comb begin
        w_acc = '0;
        for (int i = 0; i < LANES; i++) begin
            w_prod[i] = $signed(i_x[8*i +: 8]) * $signed(i_w[8*i +: 8]);
            w_acc     = w_acc + {{16{w_prod[i][15]}}, w_prod[i]};
        end
    end

    assign o_sum = w_acc;

endmodule

// File: rtl/mvm_top.sv
// AXI-Stream command endpoint: 64x32 weight file with write, read and int8 dot-product ops.
// Optional macro MVM_TOP_ONEHOT_CHECK_EN discards commands whose row select has more than one bit set.
module mvm_top #(
    parameter int               TDATAW     = mvm_pkg::TDATAW,
    parameter int               IDW        = mvm_pkg::IDW,
    parameter int               DESTW      = mvm_pkg::DESTW,
    parameter int               USERW      = mvm_pkg::USERW,
    parameter logic [DESTW-1:0] LOCAL_DEST = DESTW'(12'h002),
    parameter logic [DESTW-1:0] HOST_DEST  = DESTW'(12'h000)
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              CLK_NOC,

    input  logic              AXIS_S_TVALID,
    output logic              AXIS_S_TREADY,
    input  logic [TDATAW-1:0] AXIS_S_TDATA,
    input  logic [IDW-1:0]    AXIS_S_TID,
    input  logic [USERW-1:0]  AXIS_S_TUSER,
    input  logic [DESTW-1:0]  AXIS_S_TDEST,
    input  logic              AXIS_S_TLAST,

    output logic              AXIS_M_TVALID,
    input  logic              AXIS_M_TREADY,
    output logic [TDATAW-1:0] AXIS_M_TDATA,
    output logic [IDW-1:0]    AXIS_M_TID,
    output logic [USERW-1:0]  AXIS_M_TUSER,
    output logic [DESTW-1:0]  AXIS_M_TDEST,
    output logic              AXIS_M_TLAST
);
    import mvm_pkg::*;

    logic [31:0]       r_rows [NROWS];
    logic              r_m_valid;
    logic [TDATAW-1:0] r_m_data;
    logic [IDW-1:0]    r_m_id;
    logic [USERW-1:0]  r_m_user;
    logic [DESTW-1:0]  r_m_dest;
    logic              r_m_last;

    logic              w_accept;
    logic [31:0]       w_data;
    logic              w_cmd_vld;
    opcode_e           w_op;
    logic [NROWS-1:0]  w_sel;
    logic              w_sel_ok;
    logic [ROW_AW-1:0] w_row_idx;
    logic [31:0]       w_row;
    logic [31:0]       w_dot;
    logic [31:0]       w_resp;
    logic              w_cmd_ok;
    logic              w_do_write;
    logic              w_do_resp;
    logic              w_unused;

    assign AXIS_S_TREADY = !r_m_valid || AXIS_M_TREADY;
    assign w_accept      = AXIS_S_TVALID && AXIS_S_TREADY;

    assign w_data    = AXIS_S_TDATA[DATA_MSB:DATA_LSB];
    assign w_cmd_vld = AXIS_S_TDATA[VALID_BIT];
    assign w_op      = opcode_e'(AXIS_S_TDATA[OP_MSB:OP_LSB]);
    assign w_sel     = AXIS_S_TDATA[SEL_MSB:SEL_LSB];

`ifdef MVM_TOP_ONEHOT_CHECK_EN
    assign w_sel_ok = (|w_sel) && ((w_sel & (w_sel - NROWS'(1))) == '0);
`else
    assign w_sel_ok = |w_sel;
`endif

    assign w_row_idx = lowest_set(w_sel);
    assign w_row     = r_rows[w_row_idx];

    mvm_dot4 u_dot4 (
        .i_x   (w_data),
        .i_w   (w_row),
        .o_sum (w_dot)
    );

    assign w_cmd_ok   = w_accept && (AXIS_S_TDEST == LOCAL_DEST) && w_cmd_vld && w_sel_ok;
    assign w_do_write = w_cmd_ok && (w_op == OP_WRITE);
    assign w_do_resp  = w_cmd_ok && ((w_op == OP_READ) || (w_op == OP_MVM));
    assign w_resp     = (w_op == OP_MVM) ? w_dot : w_row;

    // Upper tdata bits, TLAST and the legacy NoC clock are intentionally ignored.
    assign w_unused = &{1'b0, CLK_NOC, AXIS_S_TLAST, AXIS_S_TDATA[TDATAW-1:SEL_MSB+1]};

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NROWS; i++) begin
                r_rows[i] <= '0;
            end
        end else if (w_do_write) begin
            r_rows[w_row_idx] <= w_data;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_id    <= '0;
            r_m_user  <= '0;
            r_m_dest  <= '0;
            r_m_last  <= 1'b0;
        end else if (w_do_resp) begin
            r_m_valid <= 1'b1;
            r_m_data  <= TDATAW'(w_resp);
            r_m_id    <= AXIS_S_TID;
            r_m_user  <= AXIS_S_TUSER;
            r_m_dest  <= HOST_DEST;
            r_m_last  <= 1'b1;
        end else if (AXIS_M_TREADY) begin
            r_m_valid <= 1'b0;
        end
    end

    assign AXIS_M_TVALID = r_m_valid;
    assign AXIS_M_TDATA  = r_m_data;
    assign AXIS_M_TID    = r_m_id;
    assign AXIS_M_TUSER  = r_m_user;
    assign AXIS_M_TDEST  = r_m_dest;
    assign AXIS_M_TLAST  = r_m_last;

endmodule

// File: tb/tb_mvm_top.sv
// Directed self-checking bench for mvm_top; expectations follow MVM_TOP_ONEHOT_CHECK_EN if defined.
module tb_mvm_top;

    logic         CLK = 1'b0;
    logic         CLK_NOC = 1'b0;
    logic         RST_N = 1'b0;
    logic         AXIS_S_TVALID = 1'b0;
    logic         AXIS_S_TREADY;
    logic [127:0] AXIS_S_TDATA = '0;
    logic [31:0]  AXIS_S_TID = '0;
    logic [31:0]  AXIS_S_TUSER = '0;
    logic [11:0]  AXIS_S_TDEST = '0;
    logic         AXIS_S_TLAST = 1'b0;
    logic         AXIS_M_TVALID;
    logic         AXIS_M_TREADY = 1'b1;
    logic [127:0] AXIS_M_TDATA;
    logic [31:0]  AXIS_M_TID;
    logic [31:0]  AXIS_M_TUSER;
    logic [11:0]  AXIS_M_TDEST;
    logic         AXIS_M_TLAST;

    int n_assert = 0;
    int n_fail   = 0;

    localparam logic [1:0] OPC_NOP = 2'b00, OPC_RD = 2'b01, OPC_MVM = 2'b10, OPC_WR = 2'b11;

    always #5 CLK = ~CLK;
    always #7 CLK_NOC = ~CLK_NOC;

    mvm_top dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .CLK_NOC       (CLK_NOC),
        .AXIS_S_TVALID (AXIS_S_TVALID),
        .AXIS_S_TREADY (AXIS_S_TREADY),
        .AXIS_S_TDATA  (AXIS_S_TDATA),
        .AXIS_S_TID    (AXIS_S_TID),
        .AXIS_S_TUSER  (AXIS_S_TUSER),
        .AXIS_S_TDEST  (AXIS_S_TDEST),
        .AXIS_S_TLAST  (AXIS_S_TLAST),
        .AXIS_M_TVALID (AXIS_M_TVALID),
        .AXIS_M_TREADY (AXIS_M_TREADY),
        .AXIS_M_TDATA  (AXIS_M_TDATA),
        .AXIS_M_TID    (AXIS_M_TID),
        .AXIS_M_TUSER  (AXIS_M_TUSER),
        .AXIS_M_TDEST  (AXIS_M_TDEST),
        .AXIS_M_TLAST  (AXIS_M_TLAST)
    );

    // Drive one beat at the falling edge, return 1 time unit after the next rising edge.
    task automatic issue(input logic vld, input logic [1:0] op, input logic [63:0] sel,
                         input logic [31:0] data, input logic [11:0] dest, input logic [31:0] id);
        @(negedge CLK);
        AXIS_S_TVALID = 1'b1;
        AXIS_S_TDATA  = {29'h1555_5555, sel, op, vld, data};
        AXIS_S_TDEST  = dest;
        AXIS_S_TID    = id;
        AXIS_S_TUSER  = id ^ 32'hA5A5_0000;
        AXIS_S_TLAST  = id[0];
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        @(negedge CLK);
        AXIS_S_TVALID = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        #13;
        n_assert++;
        if (AXIS_S_TREADY !== 1'b1) begin
            $display("FAIL reset_s_tready: got %b want 1", AXIS_S_TREADY); n_fail++;
        end
        n_assert++;
        if (AXIS_M_TVALID !== 1'b0 || AXIS_M_TDATA !== '0 || AXIS_M_TDEST !== '0 || AXIS_M_TLAST !== 1'b0) begin
            $display("FAIL reset_m_outputs: got v=%b d=%h dest=%h last=%b want all 0",
                     AXIS_M_TVALID, AXIS_M_TDATA, AXIS_M_TDEST, AXIS_M_TLAST); n_fail++;
        end
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        n_assert++;
        if (AXIS_S_TREADY !== 1'b1) begin
            $display("FAIL post_reset_s_tready: got %b want 1", AXIS_S_TREADY); n_fail++;
        end
    endtask

    task automatic test_wrong_dest();
        issue(1'b1, OPC_WR, 64'h1, 32'h0000_1234, 12'h003, 32'h1);
        n_assert++;
        if (AXIS_M_TVALID !== 1'b0) begin
            $display("FAIL wrong_dest_no_resp: got tvalid %b want 0", AXIS_M_TVALID); n_fail++;
        end
        issue(1'b1, OPC_RD, 64'h1, 32'h0, 12'h002, 32'h2);
        n_assert++;
        if (AXIS_M_TVALID !== 1'b1 || AXIS_M_TDATA !== 128'h0) begin
            $display("FAIL wrong_dest_row0: got v=%b d=%h want v=1 d=0", AXIS_M_TVALID, AXIS_M_TDATA); n_fail++;
        end
        idle();
    endtask

    task automatic test_discard();
        issue(1'b0, OPC_WR, 64'h2, 32'h0000_0077, 12'h002, 32'h3);
        issue(1'b1, OPC_WR, 64'h0, 32'h0000_0066, 12'h002, 32'h4);
        issue(1'b1, OPC_NOP, 64'h2, 32'h0000_0055, 12'h002, 32'h5);
        n_assert++;
        if (AXIS_M_TVALID !== 1'b0) begin
            $display("FAIL nop_no_resp: got tvalid %b want 0", AXIS_M_TVALID); n_fail++;
        end
        issue(1'b0, OPC_RD, 64'h2, 32'h0, 12'h002, 32'h6);
        n_assert++;
        if (AXIS_M_TVALID !== 1'b0) begin
            $display("FAIL invalid_read_no_resp: got tvalid %b want 0", AXIS_M_TVALID); n_fail++;
        end
        issue(1'b1, OPC_RD, 64'h0, 32'h0, 12'h002, 32'h7);
        n_assert++;
        if (AXIS_M_TVALID !== 1'b0) begin
            $display("FAIL zero_sel_read_no_resp: got tvalid %b want 0", AXIS_M_TVALID); n_fail++;
        end
        issue(1'b1, OPC_RD, 64'h2, 32'h0, 12'h002, 32'h8);
        n_assert++;
        if (AXIS_M_TVALID !== 1'b1 || AXIS_M_TDATA !== 128'h0) begin
            $display("FAIL discard_row1: got v=%b d=%h want v=1 d=0", AXIS_M_TVALID, AXIS_M_TDATA); n_fail++;
        end
        idle();
    endtask

    task automatic test_write_all_read();
        int bad;
        bad = 0;
        for (int k = 0; k < 64; k++) begin
            issue(1'b1, OPC_WR, 64'd1 << k, 32'h0000_00AB, 12'h002, 32'(k));
            if (AXIS_M_TVALID !== 1'b0) bad++;
        end
        n_assert++;
        if (bad != 0) begin
            $display("FAIL write_no_resp: %0d writes produced a response, want 0", bad); n_fail++;
        end
        issue(1'b1, OPC_RD, 64'd1 << 5, 32'h0, 12'h002, 32'h0000_0011);
        n_assert++;
        if (AXIS_M_TVALID !== 1'b1 || AXIS_M_TDATA !== 128'hAB) begin
            $display("FAIL read_row5: got v=%b d=%h want v=1 d=ab", AXIS_M_TVALID, AXIS_M_TDATA); n_fail++;
        end
        n_assert++;
        if (AXIS_M_TDEST !== 12'h000 || AXIS_M_TLAST !== 1'b1 || AXIS_M_TID !== 32'h11 ||
            AXIS_M_TUSER !== (32'h11 ^ 32'hA5A5_0000)) begin
            $display("FAIL read_row5_sideband: got dest=%h last=%b id=%h user=%h want 000 1 11 a5a50011",
                     AXIS_M_TDEST, AXIS_M_TLAST, AXIS_M_TID, AXIS_M_TUSER); n_fail++;
        end
        issue(1'b1, OPC_RD, 64'd1 << 63, 32'h0, 12'h002, 32'h0000_0012);
        n_assert++;
        if (AXIS_M_TVALID !== 1'b1 || AXIS_M_TDATA !== 128'hAB) begin
            $display("FAIL read_row63: got v=%b d=%h want v=1 d=ab", AXIS_M_TVALID, AXIS_M_TDATA); n_fail++;
        end
        idle();
        n_assert++;
        if (AXIS_M_TVALID !== 1'b0) begin
            $display("FAIL resp_drained: got tvalid %b want 0", AXIS_M_TVALID); n_fail++;
        end
    endtask

    task automatic test_mvm();
        issue(1'b1, OPC_WR, 64'd1 << 3, 32'h0102_0304, 12'h002, 32'h20);
        issue(1'b1, OPC_MVM, 64'd1 << 3, 32'hFF01_0203, 12'h002, 32'h21);
        n_assert++;
        if (AXIS_M_TVALID !== 1'b1 || AXIS_M_TDATA !== 128'h13) begin
            $display("FAIL mvm_basic: got v=%b d=%h want v=1 d=13", AXIS_M_TVALID, AXIS_M_TDATA); n_fail++;
        end
        issue(1'b1, OPC_WR, 64'd1 << 4, 32'h8080_8080, 12'h002, 32'h22);
        issue(1'b1, OPC_MVM, 64'd1 << 4, 32'h7F7F_7F7F, 12'h002, 32'h23);
        n_assert++;
        if (AXIS_M_TDATA !== 128'hFFFF_0200) begin
            $display("FAIL mvm_negative: got %h want ffff0200", AXIS_M_TDATA); n_fail++;
        end
        issue(1'b1, OPC_MVM, 64'd1 << 4, 32'h8080_8080, 12'h002, 32'h24);
        n_assert++;
        if (AXIS_M_TDATA !== 128'h0001_0000) begin
            $display("FAIL mvm_max_pos: got %h want 00010000", AXIS_M_TDATA); n_fail++;
        end
        idle();
    endtask

    task automatic test_multi_select();
        logic [31:0] exp0;
`ifdef MVM_TOP_ONEHOT_CHECK_EN
        exp0 = 32'h0000_00AB;
`else
        exp0 = 32'h0000_0055;
`endif
        issue(1'b1, OPC_WR, 64'h3, 32'h0000_0055, 12'h002, 32'h30);
        issue(1'b1, OPC_RD, 64'h1, 32'h0, 12'h002, 32'h31);
        n_assert++;
        if (AXIS_M_TDATA !== {96'h0, exp0}) begin
            $display("FAIL multi_sel_row0: got %h want %h", AXIS_M_TDATA, exp0); n_fail++;
        end
        issue(1'b1, OPC_RD, 64'h2, 32'h0, 12'h002, 32'h32);
        n_assert++;
        if (AXIS_M_TDATA !== 128'hAB) begin
            $display("FAIL multi_sel_row1: got %h want ab", AXIS_M_TDATA); n_fail++;
        end
        idle();
    endtask

    task automatic test_backpressure();
        int bad;
        bad = 0;
        AXIS_M_TREADY = 1'b0;
        issue(1'b1, OPC_RD, 64'd1 << 3, 32'h0, 12'h002, 32'h40);
        n_assert++;
        if (AXIS_M_TVALID !== 1'b1 || AXIS_M_TDATA !== 128'h0102_0304 || AXIS_M_TID !== 32'h40) begin
            $display("FAIL bp_first: got v=%b d=%h id=%h want 1 01020304 40",
                     AXIS_M_TVALID, AXIS_M_TDATA, AXIS_M_TID); n_fail++;
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            AXIS_S_TDATA = {29'h0, 64'd1 << 4, OPC_RD, 1'b1, 32'h0};
            AXIS_S_TID   = 32'h41;
            @(posedge CLK);
            #1;
            if (AXIS_M_TVALID !== 1'b1 || AXIS_M_TDATA !== 128'h0102_0304 ||
                AXIS_M_TID !== 32'h40 || AXIS_S_TREADY !== 1'b0) bad++;
        end
        n_assert++;
        if (bad != 0) begin
            $display("FAIL bp_hold: %0d stalled cycles unstable or s_tready high, want 0", bad); n_fail++;
        end
        @(negedge CLK);
        AXIS_M_TREADY = 1'b1;
        #1;
        n_assert++;
        if (AXIS_S_TREADY !== 1'b1) begin
            $display("FAIL bp_release_tready: got %b want 1", AXIS_S_TREADY); n_fail++;
        end
        @(posedge CLK);
        #1;
        n_assert++;
        if (AXIS_M_TVALID !== 1'b1 || AXIS_M_TDATA !== 128'h8080_8080 || AXIS_M_TID !== 32'h41) begin
            $display("FAIL bp_second: got v=%b d=%h id=%h want 1 80808080 41",
                     AXIS_M_TVALID, AXIS_M_TDATA, AXIS_M_TID); n_fail++;
        end
        idle();
        n_assert++;
        if (AXIS_M_TVALID !== 1'b0) begin
            $display("FAIL bp_drained: got tvalid %b want 0", AXIS_M_TVALID); n_fail++;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_d [3];
        logic [63:0] sel_d [3];
        int bad;
        exp_d = '{32'h0102_0304, 32'h8080_8080, 32'hDEAD_BEEF};
        sel_d = '{64'd1 << 3, 64'd1 << 4, 64'd1 << 10};
        issue(1'b1, OPC_WR, 64'd1 << 10, 32'hDEAD_BEEF, 12'h002, 32'h50);
        issue(1'b1, OPC_RD, 64'd1 << 10, 32'h0, 12'h002, 32'h51);
        n_assert++;
        if (AXIS_M_TVALID !== 1'b1 || AXIS_M_TDATA !== 128'hDEAD_BEEF) begin
            $display("FAIL wr_then_rd: got v=%b d=%h want 1 deadbeef", AXIS_M_TVALID, AXIS_M_TDATA); n_fail++;
        end
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            issue(1'b1, OPC_RD, sel_d[i], 32'h0, 12'h002, 32'(8'h60 + i));
            if (AXIS_M_TVALID !== 1'b1 || AXIS_M_TDATA !== {96'h0, exp_d[i]} ||
                AXIS_M_TID !== 32'(8'h60 + i) || AXIS_S_TREADY !== 1'b1) bad++;
        end
        n_assert++;
        if (bad != 0) begin
            $display("FAIL back_to_back: %0d of 3 responses wrong, want 0", bad); n_fail++;
        end
        idle();
    endtask

    task automatic test_reset_pending();
        AXIS_M_TREADY = 1'b0;
        issue(1'b1, OPC_RD, 64'd1 << 3, 32'h0, 12'h002, 32'h70);
        n_assert++;
        if (AXIS_M_TVALID !== 1'b1) begin
            $display("FAIL rst_pending_setup: got tvalid %b want 1", AXIS_M_TVALID); n_fail++;
        end
        @(negedge CLK);
        AXIS_S_TVALID = 1'b0;
        RST_N = 1'b0;
        #1;
        n_assert++;
        if (AXIS_M_TVALID !== 1'b0 || AXIS_M_TDATA !== '0 || AXIS_S_TREADY !== 1'b1) begin
            $display("FAIL rst_pending_clear: got v=%b d=%h s_rdy=%b want 0 0 1",
                     AXIS_M_TVALID, AXIS_M_TDATA, AXIS_S_TREADY); n_fail++;
        end
        @(negedge CLK);
        RST_N = 1'b1;
        AXIS_M_TREADY = 1'b1;
        issue(1'b1, OPC_RD, 64'd1 << 3, 32'h0, 12'h002, 32'h71);
        n_assert++;
        if (AXIS_M_TVALID !== 1'b1 || AXIS_M_TDATA !== 128'h0) begin
            $display("FAIL rst_row3: got v=%b d=%h want 1 0", AXIS_M_TVALID, AXIS_M_TDATA); n_fail++;
        end
        issue(1'b1, OPC_RD, 64'd1 << 10, 32'h0, 12'h002, 32'h72);
        n_assert++;
        if (AXIS_M_TVALID !== 1'b1 || AXIS_M_TDATA !== 128'h0) begin
            $display("FAIL rst_row10: got v=%b d=%h want 1 0", AXIS_M_TVALID, AXIS_M_TDATA); n_fail++;
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_wrong_dest();
        test_discard();
        test_write_all_read();
        test_mvm();
        test_multi_select();
        test_backpressure();
        test_back_to_back();
        test_reset_pending();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mvm_top.md
MVM_TOP -- requirements
Module: mvm_top

Interface
REQ-001 Parameter TDATAW, default 128, AXI-Stream tdata width in bits (min 100).
REQ-002 Parameter IDW, default 32, tid width.
REQ-003 Parameter DESTW, default 12, tdest width.
REQ-004 Parameter USERW, default 32, tuser width.
REQ-005 Parameter LOCAL_DEST, default 12'h002, NoC address of this block.
REQ-006 Parameter HOST_DEST, default 12'h000, tdest placed on every response.
REQ-007 One clock; reset is asynchronous and active-low: CLK, RST_N.
REQ-008 CLK  input  1  sole clock; all state on rising edge.
REQ-009 RST_N  input  1  asynchronous active-low reset.
REQ-010 CLK_NOC  input  1  kept for port compatibility; SHALL clock no logic.
REQ-011 AXIS_S_TVALID/TREADY  in/out  1/1  slave handshake.
REQ-012 AXIS_S_TDATA  input  TDATAW  command beat.
REQ-013 AXIS_S_TID/TUSER/TDEST/TLAST  input  IDW/USERW/DESTW/1  sideband.
REQ-014 AXIS_M_TVALID/TREADY  out/in  1/1  master handshake.
REQ-015 AXIS_M_TDATA/TID/TUSER/TDEST/TLAST  output  TDATAW/IDW/USERW/DESTW/1  response beat.

Function
REQ-016 Beat format: [31:0] data; [32] command valid; [34:33] opcode; [98:35] one-hot row select, bit 35+k = row k (k=0..63); bits above 98 ignored.
REQ-017 SHALL hold a 64 x 32-bit register file (weight rows).
REQ-018 Beat accepted when AXIS_S_TVALID && AXIS_S_TREADY; each beat is a complete command, TLAST ignored.
REQ-019 Accepted beats with TDEST != LOCAL_DEST, [32]=0, or zero select field SHALL be discarded with no effect.
REQ-020 Opcode 2'b11 (write): row k <= data; visible to a command accepted the next cycle; no response.
REQ-021 Opcode 2'b01 (read): respond with TDATA[31:0] = row k, upper bits 0.
REQ-022 Opcode 2'b10 (mvm): data = four signed int8 inputs x[i] at [8i+7:8i]; row k = four signed int8 weights w[i] at same lanes; respond with TDATA[31:0] = sign-extended sum of x[i]*w[i], upper bits 0.
REQ-023 Opcode 2'b00: discarded.
REQ-024 Response: registered, AXIS_M_TVALID asserted the cycle after acceptance; TID/TUSER echo the command; TDEST=HOST_DEST; TLAST=1.
REQ-025 Response held stable until AXIS_M_TREADY; AXIS_S_TREADY = !AXIS_M_TVALID || AXIS_M_TREADY (combinational).
REQ-026 Back-to-back reads with AXIS_M_TREADY=1 SHALL sustain one response per cycle.
REQ-027 Write and read of the same row in consecutive cycles SHALL return the new value.

Reset
REQ-028 On RST_N low: all rows 0, AXIS_M_TVALID 0, all AXIS_M_* data/sideband 0; pending response lost.
REQ-029 AXIS_S_TREADY SHALL be 1 during and after reset (no response pending).

Configuration
REQ-030 Macro MVM_TOP_ONEHOT_CHECK_EN defined: select field with more than one bit set SHALL discard the command.
REQ-031 Macro MVM_TOP_ONEHOT_CHECK_EN undefined: lowest set select bit chooses the row.

Structure
REQ-032 Shared package mvm_pkg holds TDATAW/IDW/DESTW/USERW, field bit positions, and the opcode enum (NOP, READ, MVM, WRITE).
REQ-033 One sub-module mvm_dot4: combinational 4-lane signed int8 dot product, 32-bit result.

Verification
REQ-034 Write 0x0000_00AB to rows 0..63 in turn (opcode 11, TDEST 002), then read row 5 -> response TDATA[31:0]=0x0000_00AB, TDEST 000, TLAST 1.
REQ-035 Write row 3 = 0x01_02_03_04, mvm with data 0xFF_01_02_03 -> result 0x0000_0013 (4*3 + 3*2 + 2*1 + 1*(-1) = 19).
REQ-036 Write with TDEST 12'h003 to row 0, then read row 0 -> 0x0000_0000.
REQ-037 Read with AXIS_M_TREADY=0 for 5 cycles -> AXIS_M_TVALID and data stable, AXIS_S_TREADY 0; released on the TREADY cycle.
REQ-038 Select bits 35 and 36 both set, write 0x55 -> with macro: rows 0 and 1 unchanged; without: row 0 = 0x55.
REQ-039 RST_N pulsed low while a response is pending -> AXIS_M_TVALID 0 immediately, rows read back 0.
